// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets, sync polarities and colour-bar table
package vga_pkg;

  localparam logic SYNC_POS = 1'b1;
  localparam logic SYNC_NEG = 1'b0;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int   VGA640_H_SYNC   = 96;
  localparam int   VGA640_H_BP     = 48;
  localparam int   VGA640_H_ACT    = 640;
  localparam int   VGA640_H_FP     = 16;
  localparam int   VGA640_V_SYNC   = 2;
  localparam int   VGA640_V_BP     = 33;
  localparam int   VGA640_V_ACT    = 480;
  localparam int   VGA640_V_FP     = 10;
  localparam logic VGA640_SYNC_POL = SYNC_NEG;

  // 800x600@72 (50 MHz pixel clock)
  localparam int   SVGA800_H_SYNC   = 120;
  localparam int   SVGA800_H_BP     = 64;
  localparam int   SVGA800_H_ACT    = 800;
  localparam int   SVGA800_H_FP     = 56;
  localparam int   SVGA800_V_SYNC   = 6;
  localparam int   SVGA800_V_BP     = 23;
  localparam int   SVGA800_V_ACT    = 600;
  localparam int   SVGA800_V_FP     = 37;
  localparam logic SVGA800_SYNC_POL = SYNC_POS;

  // {r,g,b}: black, blue, green, cyan, red, magenta, yellow, white
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111
  };

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - ce-qualified shift register, DEPTH=0 is a plain wire
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ ce;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with pixel-latency compensation
// Define VGA_TESTPAT_EN to add test_mode and the internal 8-bar colour generator.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CNT_W    = 12,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACT    = 640,
  parameter int   H_FP     = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACT    = 480,
  parameter int   V_FP     = 10,
  parameter logic SYNC_POL = 1'b1,
  parameter int   RGB_W    = 1,
  parameter int   PIX_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
`ifdef VGA_TESTPAT_EN
  input  logic             test_mode,
`endif
  input  logic [RGB_W-1:0] pixel_r,
  input  logic [RGB_W-1:0] pixel_g,
  input  logic [RGB_W-1:0] pixel_b,
  output logic             req_valid,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic [RGB_W-1:0] vga_r,
  output logic [RGB_W-1:0] vga_g,
  output logic [RGB_W-1:0] vga_b,
  output logic             vga_hsy,
  output logic             vga_vsy,
  output logic             vga_de,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SW   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SW   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_BEG  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_BEG  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_SYNC + V_BP + V_ACT);

  if (H_ACT % 8 != 0) begin : g_bad_h_act
    $error("vga_timing_gen: H_ACT must be divisible by 8");
  end
  if (H_TOT >= (1 << CNT_W) || V_TOT >= (1 << CNT_W)) begin : g_bad_totals
    $error("vga_timing_gen: H_TOT/V_TOT do not fit in CNT_W bits");
  end
  if (PIX_LAT < 0 || PIX_LAT > 15) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT must be 0..15");
  end

  logic [CNT_W-1:0] hcnt, vcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  logic h_act, v_act;
  logic hs_raw, vs_raw, de_raw, fs_raw, ls_raw;

  assign h_act     = (hcnt >= H_BEG) && (hcnt < H_END);
  assign v_act     = (vcnt >= V_BEG) && (vcnt < V_END);
  assign req_valid = h_act && v_act;
  assign req_x     = req_valid ? hcnt - H_BEG : '0;
  assign req_y     = req_valid ? vcnt - V_BEG : '0;

  // Syncs travel active-high so a cleared pipe reads as inactive.
  assign hs_raw = (hcnt < H_SW);
  assign vs_raw = (vcnt < V_SW);
  assign de_raw = req_valid;
  assign ls_raw = req_valid && (req_x == '0);
  assign fs_raw = ls_raw && (req_y == '0);

  logic [RGB_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TESTPAT_EN
  localparam int DL_W = 9;
  logic [DL_W-1:0]  dl_d, dl_q;
  logic [CNT_W-1:0] bar_idx;
  logic [2:0]       bar_rgb;

  assign bar_idx = req_x / CNT_W'(H_ACT / 8);
  assign bar_rgb = BAR_RGB[bar_idx[2:0]];
  assign dl_d    = {test_mode, bar_rgb, hs_raw, vs_raw, de_raw, fs_raw, ls_raw};
  // Mode bit rides the pipe so switching lands on an exact pixel boundary.
  assign src_r   = dl_q[8] ? {RGB_W{dl_q[7]}} : pixel_r;
  assign src_g   = dl_q[8] ? {RGB_W{dl_q[6]}} : pixel_g;
  assign src_b   = dl_q[8] ? {RGB_W{dl_q[5]}} : pixel_b;
`else
  localparam int DL_W = 5;
  logic [DL_W-1:0] dl_d, dl_q;

  assign dl_d  = {hs_raw, vs_raw, de_raw, fs_raw, ls_raw};
  assign src_r = pixel_r;
  assign src_g = pixel_g;
  assign src_b = pixel_b;
`endif

  vga_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (PIX_LAT)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (dl_d),
    .q   (dl_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsy     <= ~SYNC_POL;
      vga_vsy     <= ~SYNC_POL;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (ce) begin
      vga_hsy     <= dl_q[4] ^ ~SYNC_POL;
      vga_vsy     <= dl_q[3] ^ ~SYNC_POL;
      vga_de      <= dl_q[2];
      frame_start <= dl_q[1];
      line_start  <= dl_q[0];
      vga_r       <= dl_q[2] ? src_r : '0;
      vga_g       <= dl_q[2] ? src_g : '0;
      vga_b       <= dl_q[2] ? src_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a 14x7 timing
module tb_vga_timing_gen;

  localparam int CW  = 8;
  localparam int RW  = 4;
  localparam int LAT = 2;
  localparam int HS = 2, HB = 2, HA = 8, HF = 2, HT = HS + HB + HA + HF;
  localparam int VS = 1, VB = 1, VA = 4, VF = 1, VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [16:0] outs;
    logic [16:0] req;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, ce;
  logic [RW-1:0] pixel_r, pixel_g, pixel_b;
  logic          req_valid;
  logic [CW-1:0] req_x, req_y;
  logic [RW-1:0] vga_r, vga_g, vga_b;
  logic          vga_hsy, vga_vsy, vga_de, frame_start, line_start;
`ifdef VGA_TESTPAT_EN
  logic          test_mode = 1'b0;
`endif

  vga_timing_gen #(
    .CNT_W (CW), .H_SYNC (HS), .H_BP (HB), .H_ACT (HA), .H_FP (HF),
    .V_SYNC (VS), .V_BP (VB), .V_ACT (VA), .V_FP (VF),
    .SYNC_POL (1'b1), .RGB_W (RW), .PIX_LAT (LAT)
  ) dut (
    .clk (clk), .rst (rst), .ce (ce),
`ifdef VGA_TESTPAT_EN
    .test_mode (test_mode),
`endif
    .pixel_r (pixel_r), .pixel_g (pixel_g), .pixel_b (pixel_b),
    .req_valid (req_valid), .req_x (req_x), .req_y (req_y),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .vga_hsy (vga_hsy), .vga_vsy (vga_vsy), .vga_de (vga_de),
    .frame_start (frame_start), .line_start (line_start)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ce  = 0;
  exp_t        exp_q[$];
  logic [11:0] src_q[$];
  logic [11:0] fb [VA][HA];

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Screen position after n ce-edges is n mod FT; pins show position n-(LAT+1).
  function automatic exp_t model(input int n);
    exp_t e;
    int q, h, v, p;
    logic act;
    logic [11:0] rgb;
    q = n % FT; h = q % HT; v = q / HT;
    act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    e.req = act ? {1'b1, 8'(h - HS - HB), 8'(v - VS - VB)} : 17'd0;
    p = n - (LAT + 1);
    if (p < 0) begin
      e.outs = 17'd0;
    end else begin
      q = p % FT; h = q % HT; v = q / HT;
      act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      rgb = 12'h000;
      if (act) rgb = fb[v - VS - VB][h - HS - HB];
      e.outs = {(h < HS), (v < VS), act, act && (h == HS + HB) && (v == VS + VB),
                act && (h == HS + HB), rgb};
    end
    return e;
  endfunction

  // Drive one clock: inputs for the next posedge, expected result pushed for it.
  task automatic step(input logic r, input logic c);
    logic [11:0] lk;
    rst = r;
    ce  = c;
    lk  = 12'($urandom);
    if (r) begin
      n_ce = 0;
      src_q.delete();
    end else if (c) begin
      // Pixel source: frame-buffer lookup returned LAT ce-cycles after the request.
      src_q.push_back(req_valid ? fb[req_y[1:0]][req_x[2:0]] : 12'hFFF);
      if (src_q.size() > LAT) lk = src_q.pop_front();
      n_ce++;
    end
    {pixel_r, pixel_g, pixel_b} = lk;
    if (r || c) exp_q.push_back(model(n_ce));
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e, last;
    logic upd, have_last;
    have_last = 1'b0;
    last = '0;
    forever begin
      @(posedge clk);
      upd = rst || ce;
      @(negedge clk);
      if (upd) begin
        if (exp_q.size() == 0) begin
          check("underflow", 17'd1, 17'd0);
        end else begin
          e = exp_q.pop_front();
          check("outputs", {vga_hsy, vga_vsy, vga_de, frame_start, line_start,
                            vga_r, vga_g, vga_b}, e.outs);
          check("request", {req_valid, req_x, req_y}, e.req);
          last = e;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        check("hold", {vga_hsy, vga_vsy, vga_de, frame_start, line_start,
                       vga_r, vga_g, vga_b}, last.outs);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        fb[y][x] = 12'($urandom);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (2 * FT + 10) step(1'b0, 1'b1);
    for (int i = 0; i < 2 * FT; i++) step(1'b0, (i % 2) == 0);
    for (int i = 0; i < 2 * FT && (n_ce % FT) != 3 * HT + 9; i++) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (FT + 20) step(1'b0, 1'b1);
    for (int i = 0; i < 3 * FT; i++)
      step($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)));
    repeat (4) step(1'b0, 1'b0);
    check("drain", 17'(exp_q.size()), 17'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
